// File: rtl/bp_fe_pkg.sv
// Shared front-end definitions: the replay-queue payload layout and its width helper.
`define BP_FE_REPLAY_ENTRY_WIDTH(vaddr_width_mp, ptag_width_mp) (3 + (vaddr_width_mp) + (ptag_width_mp))

package bp_fe_pkg;

    localparam int vaddr_width_gp = 39;
    localparam int ptag_width_gp  = 22;

    typedef struct packed {
        logic                     dram;
        logic                     nonidem;
        logic                     uncached;
        logic [vaddr_width_gp-1:0] vaddr;
        logic [ptag_width_gp-1:0]  ptag;
    } bp_fe_replay_entry_s;

    localparam int bp_fe_replay_entry_width_gp =
        `BP_FE_REPLAY_ENTRY_WIDTH(vaddr_width_gp, ptag_width_gp);

endpackage

// File: rtl/bp_fe_replay_inflight.sv
// In-flight tracker: one bit per issued request, marching toward resolution; clear drops all.
module bp_fe_replay_inflight
    import bp_fe_pkg::*;
#(
    parameter int latency_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clr_i,
    input  logic                 v_i,
    output logic [latency_p-1:0] inf_o
);

    logic [latency_p-1:0] inf_q, inf_d;

    generate
        if (latency_p == 1) begin : g_single
            assign inf_d = v_i;
        end else begin : g_shift
            assign inf_d = {inf_q[latency_p-2:0], v_i};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)  inf_q <= '0;
        else if (clr_i)  inf_q <= '0;
        else             inf_q <= inf_d;
    end

    assign inf_o = inf_q;

endmodule

// File: rtl/bsg_mem_1r1w.sv
// 1R1W register file: synchronous write, asynchronous read, no reset on contents.
module bsg_mem_1r1w #(
    parameter int width_p       = 64,
    parameter int els_p         = 8,
    parameter int addr_width_lp = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) mem_q[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_replay_queue.sv
// In-order fetch request queue with fixed-latency resolution tracking and
// automatic rewind/replay from the oldest unresolved entry on a miss.
module bp_fe_replay_queue
    import bp_fe_pkg::*;
#(
    parameter int width_p      = 64,
    parameter int els_p        = 8,
    parameter int latency_p    = 2,
    parameter int max_replay_p = 15,
    parameter int cnt_w_lp     = $clog2(max_replay_p+1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clr_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                v_i,
    output logic                ready_and_o,
    output logic [width_p-1:0]  data_o,
    output logic                v_o,
    input  logic                yumi_i,
    output logic                resolve_v_o,
    input  logic                commit_i,
    input  logic                roll_i,
    output logic                replay_o,
    output logic [cnt_w_lp-1:0] replay_cnt_o,
    output logic                stuck_o
);

    localparam int ptr_w_lp = $clog2(els_p) + 1;
    localparam int idx_w_lp = ptr_w_lp - 1;

    logic [ptr_w_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, cptr_q, cptr_d;
    logic [ptr_w_lp-1:0]  occupancy;
    logic [cnt_w_lp-1:0]  cnt_q, cnt_d, cnt_base;
    logic                 stuck_q, stuck_d;
    logic [latency_p-1:0] inf, live_vec;
    logic                 enq, issue, commit, rollback, bump, over;

    assign occupancy   = wptr_q - cptr_q;
    assign ready_and_o = (occupancy != ptr_w_lp'(els_p));
    assign enq         = v_i & ready_and_o & ~clr_i;
    assign v_o         = (rptr_q != wptr_q);
    assign issue       = yumi_i & v_o;
    assign resolve_v_o = inf[latency_p-1];
    assign commit      = resolve_v_o & commit_i;
    assign rollback    = (resolve_v_o & ~commit_i) | roll_i;
    assign replay_o    = rollback & ~clr_i;

    // A retiring entry no longer counts as in flight when deciding whether a rollback is a replay.
    always_comb begin
        live_vec              = inf;
        live_vec[latency_p-1] = inf[latency_p-1] & ~commit;
        cnt_base              = commit ? '0 : cnt_q;
        bump                  = rollback & (|live_vec);
        over                  = bump & (cnt_base >= cnt_w_lp'(max_replay_p));

        wptr_d  = wptr_q + {{(ptr_w_lp-1){1'b0}}, enq};
        cptr_d  = cptr_q + {{(ptr_w_lp-1){1'b0}}, commit};
        rptr_d  = rollback ? cptr_d : rptr_q + {{(ptr_w_lp-1){1'b0}}, issue};
        cnt_d   = (bump && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
        stuck_d = stuck_q | over;

        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            cptr_d  = '0;
            cnt_d   = '0;
            stuck_d = stuck_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cptr_q  <= '0;
            cnt_q   <= '0;
            stuck_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cptr_q  <= cptr_d;
            cnt_q   <= cnt_d;
            stuck_q <= stuck_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) assert (!(yumi_i && !v_o));
    end

    assign replay_cnt_o = cnt_q;
    assign stuck_o      = stuck_q;

    bp_fe_replay_inflight #(
        .latency_p (latency_p)
    ) inflight (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (rollback | clr_i),
        .v_i       (issue),
        .inf_o     (inf)
    );

    bsg_mem_1r1w #(
        .width_p (width_p),
        .els_p   (els_p)
    ) mem (
        .w_clk_i  (clk_i),
        .w_v_i    (enq),
        .w_addr_i (wptr_q[idx_w_lp-1:0]),
        .w_data_i (data_i),
        .r_addr_i (rptr_q[idx_w_lp-1:0]),
        .r_data_o (data_o)
    );

endmodule

// File: doc/bp_fe_replay_queue.md
# bp_fe_replay_queue

Parametrised successor to the single-stage rolly FIFO used to feed the I$ fetch path. It buffers fetch requests, issues them in order, and tracks each issued request through a fixed-latency resolution pipe. On a miss resolution it automatically rewinds and replays from the oldest unresolved request, and it flags entries that exceed a replay limit. It sits between the PC/ptag source and `bp_fe_icache`, and is reused by the I$ and D$ unit benches.

## Interface
Parameters:
- `width_p`, 64 — payload width (vaddr, ptag, attribute bits).
- `els_p`, 8 — entries; power of two, ≥2.
- `latency_p`, 2 — cycles from issue (`v_o & yumi_i`) to resolution; ≥1.
- `max_replay_p`, 15 — replays of one head entry before `stuck_o` asserts; ≥1.

Ports:
- `clk_i` in 1 — the single clock.
- `reset_n_i` in 1 — reset, synchronous and active-low.
- `clr_i` in 1 — synchronous flush of all state except `stuck_o`.
- `data_i` in `width_p` — enqueue payload.
- `v_i` in 1 — enqueue valid.
- `ready_and_o` out 1 — enqueue ready; the transfer is `v_i & ready_and_o`.
- `data_o` out `width_p` — payload at the issue pointer.
- `v_o` out 1 — an issuable entry exists.
- `yumi_i` in 1 — consumer takes `data_o`; legal only when `v_o`.
- `resolve_v_o` out 1 — the oldest in-flight request resolves this cycle.
- `commit_i` in 1 — sampled only when `resolve_v_o`: 1 = hit/retire, 0 = miss/replay.
- `roll_i` in 1 — external rollback (e.g. redirect of a poisoned fetch).
- `replay_o` out 1 — pulse; a rollback occurs this cycle.
- `replay_cnt_o` out `$clog2(max_replay_p+1)` — replays of the current head entry.
- `stuck_o` out 1 — sticky; head replayed more than `max_replay_p` times.

## Operation
- Pointers:
  - `wptr`, `rptr` and `cptr` (write, read/issue, commit) are each `$clog2(els_p)+1` bits; the extra wrap bit distinguishes full from empty.
  - Occupancy is `wptr - cptr`; it is full when equal to `els_p`.
  - Issuable when `rptr != wptr`.
- Enqueue: when `v_i & ready_and_o`, write storage at `wptr` and increment `wptr`. `ready_and_o = ~full`, computed from registered state only; space freed by a same-cycle commit is not bypassed.
- Issue:
  - `v_o = (rptr != wptr)`; `data_o = mem[rptr]`.
  - On `yumi_i`, increment `rptr` and shift a 1 into in-flight shift register `inf_r[latency_p-1:0]`; otherwise shift in 0.
  - `resolve_v_o = inf_r[latency_p-1]`.
- Resolution:
  - `resolve_v_o & commit_i` (retire): increment `cptr` and zero `replay_cnt`.
  - `resolve_v_o & ~commit_i` (miss), or `roll_i`: rollback.
- Rollback:
  - `rptr` is loaded with `cptr` after any same-cycle commit; `inf_r` is cleared, including a same-cycle issue, which is dropped and reissued later.
  - `replay_o` is 1.
  - `replay_cnt` increments and saturates at its maximum. It does not increment for `roll_i` when there is no in-flight entry.
  - If `replay_cnt` would exceed `max_replay_p`, `stuck_o` sets.
- Simultaneous events:
  - Commit and `roll_i` in the same cycle: the commit applies first.
  - Enqueue during rollback: the enqueue proceeds normally.
  - `clr_i` overrides everything: all pointers go to 0, `inf_r` to 0, `replay_cnt` to 0. `stuck_o` is held; only reset clears it.
- `yumi_i` without `v_o` is illegal: assertion, no state change.
- `commit_i` is ignored when `resolve_v_o` is 0.
- Pointer arithmetic is modulo `2*els_p`; storage is indexed by the low `$clog2(els_p)` bits.

## Timing
- Reset values:
  - `ready_and_o` = 1.
  - `v_o`, `resolve_v_o`, `replay_o`, `stuck_o` = 0.
  - `replay_cnt_o` = 0.
  - `data_o` is don't-care.
- Latencies:
  - Enqueue to `v_o`: 1 cycle; no same-cycle bypass.
  - Issue to `resolve_v_o`: exactly `latency_p` cycles.
  - Rollback cycle t: the replayed head is on `data_o` with `v_o` at t+1.
- Issue throughput is 1 per cycle with no bubbles absent rollback.
- Reset asserted mid-operation: all state is lost at the next edge, identical to power-up.

## Structure
- Storage is a 1R1W async-read register file `bsg_mem_1r1w` (`els_p` × `width_p`).
- The in-flight tracker is sub-module `bp_fe_replay_inflight`: shift register plus clear, with `latency_p` as a parameter.
- Shared package `bp_fe_pkg` holds the payload struct `bp_fe_replay_entry_s` {dram, nonidem, uncached, vaddr, ptag} and the `bp_fe_replay_entry_width` macro.

## Test plan
1. Stream: enqueue A–D with `yumi_i=1`, `latency_p=2`, `commit_i=1` throughout -> A–D issued on consecutive cycles; `resolve_v_o` 2 cycles after each issue; empty and `ready_and_o=1` at the end.
2. Miss replay: issue A, B, C; `commit_i=0` when A resolves -> `replay_o` pulse, `replay_cnt_o=1`; next cycle `data_o=A`, then A, B, C reissue; committing A resets `replay_cnt_o` to 0.
3. Full/wrap: `els_p=8`, enqueue 8 without commits -> `ready_and_o=0`. Commit 1 -> `ready_and_o=1` the next cycle; the 9th entry stored at index 0 issues correctly.
4. Simultaneous events: at A's resolution with `commit_i=1`, raise `roll_i` and issue C in the same cycle -> A retires; replay starts at B; C is reissued after B.
5. Stuck: `max_replay_p=3`, always `commit_i=0` -> `stuck_o` sets on the 4th replay and stays set through `clr_i`; reset clears it.
6. Reset mid-flight: assert `reset_n_i=0` with 5 entries and 2 in flight -> all outputs at reset values the next cycle; no `resolve_v_o` afterward.
